// File: rtl/dac_spi_tx_pkg.sv
// Shared types and constants for the DAC SPI transmitter.
// Holds the FSM state enum and frame layout constants.
package dac_spi_tx_pkg;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 12;

  // Upper nibble of every frame ahead of the 12-bit code.
  localparam logic [3:0] CTRL_PREFIX = 4'b0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_GAP   = 2'b10,
    S_ILL   = 2'b11
  } state_t;

endpackage

// File: rtl/dac_spi_tx_tick_gen.sv
// Half-period tick generator for the DAC SPI clock.
// Ports: clk, clr (sync clear), tick (high on last clk of a half-period).
module spi_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;

  assign tick = (cnt_q == DIV_M1);

  always_ff @(posedge clk) begin
    if (clr || tick)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 8'd1;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit DAC codes into 16-bit SPI frames, MSB first.
// Ports: clk, rst, en, din, trunc in; dac_sclk/sync_n/sdo, busy, frame_done, clip_cnt out.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        trunc,
  output logic              dac_sclk,
  output logic              dac_sync_n,
  output logic              dac_sdo,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       clip_cnt
);

  localparam logic [7:0] GAP_M1 = 8'(FRAME_GAP - 1);

  state_t state_q, state_d;

  logic [FRAME_W-1:0] sh_q;
  logic [FRAME_W-1:0] word;
  logic [4:0]         half_q;
  logic [7:0]         gap_q;
  logic [15:0]        clip_q;
  logic               sclk_q, sync_q, sdo_q;
  logic               busy_q, done_q;
  logic               tick, start, last, gap_end;

  assign word    = {CTRL_PREFIX, din};
  assign start   = (state_q == S_IDLE) && en;
  assign last    = (state_q == S_SHIFT) && tick
                   && (half_q == 5'd31);
  assign gap_end = (state_q == S_GAP)
                   && (gap_q == GAP_M1);

  // Restart the divider on capture so every frame
  // begins with a full-length high half-period.
  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .clr  (rst || start),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en) state_d = S_SHIFT;
      S_SHIFT: if (last) state_d = S_GAP;
      S_GAP:   if (gap_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      half_q <= '0;
      gap_q  <= '0;
      clip_q <= '0;
      sclk_q <= 1'b1;
      sync_q <= 1'b1;
      sdo_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          sclk_q <= 1'b1;
          sync_q <= !en;
          sdo_q  <= en ? word[FRAME_W-1] : 1'b0;
          if (en) begin
            sh_q   <= word;
            half_q <= '0;
            if (trunc != 2'b00 && clip_q != 16'hFFFF)
              clip_q <= clip_q + 16'd1;
          end
        end
        S_SHIFT: begin
          if (last) begin
            sclk_q <= 1'b1;
            sync_q <= 1'b1;
            sdo_q  <= 1'b0;
            done_q <= 1'b1;
            gap_q  <= '0;
          end else if (tick) begin
            half_q <= half_q + 5'd1;
            sclk_q <= half_q[0];
            // Data moves only at a bit boundary,
            // i.e. on the rising SCLK half.
            if (half_q[0]) begin
              sh_q  <= {sh_q[FRAME_W-2:0], 1'b0};
              sdo_q <= sh_q[FRAME_W-2];
            end
          end
        end
        S_GAP: gap_q <= gap_q + 8'd1;
        default: begin
          sclk_q <= 1'b1;
          sync_q <= 1'b1;
          sdo_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_q;
  assign dac_sdo    = sdo_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign clip_cnt   = clip_q;

endmodule
